prio_req_granter: RTL and testbench

Fixed-priority request granter feeding the priority-if decision stage. Captures up to N_REQ request pulses into a sticky pending register and selects the winning index with a priority-if chain where the lowest index wins. Presents one grant at a time on a valid/ready handshake. Drops a grant if the consumer stalls past a bounded wait.

---
 rtl/prio_req_granter.sv | 137 +++++++++++++
 tb/tb_prio_req_granter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_req_granter.sv
// prio_req_granter
//   Fixed-priority request granter. Request pulses are captured in a sticky
//   pending register; an IDLE/GRANT FSM picks the lowest pending index and
//   presents it on a valid/ready handshake. A grant that is not accepted
//   within WAIT_MAX cycles is dropped, and a one-cycle timeout pulse follows.
//
//   state | meaning
//   IDLE  | no grant presented; selects the winner from pend when non-zero
//   GRANT | grant presented and held; waits for ready or the wait limit
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   req_i         request pulses/levels, bit 0 highest priority
//   gnt_valid_o   grant presented
//   gnt_ready_i   consumer accepts the grant
//   gnt_idx_o     granted index
//   gnt_onehot_o  one-hot of gnt_idx_o, zero while no grant is presented
//   timeout_o     one-cycle pulse after a grant is dropped
//   busy_o        pending requests exist or a grant is presented
//   multi_hit_o   (PRIO_MULTI_HIT_EN only) more than one request was pending
//                 when the current grant was selected
//
// Optional feature macro: PRIO_MULTI_HIT_EN
// All outputs are registered.

module prio_req_granter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = $clog2(N_REQ),
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic             gnt_valid_o,
  input  logic             gnt_ready_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [N_REQ-1:0] gnt_onehot_o,
  output logic             timeout_o,
`ifdef PRIO_MULTI_HIT_EN
  output logic             multi_hit_o,
`endif
  output logic             busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] pend_clr;
  logic [N_REQ-1:0] pend_n;
  logic [7:0]       wait_cnt;
  logic             at_limit;
  logic             release_gnt;
  logic [IDX_W-1:0] sel_idx;
  logic [N_REQ-1:0] sel_onehot;

  assign at_limit    = (wait_cnt == 8'(WAIT_MAX - 1));
  assign release_gnt = (state == GRANT) && (gnt_ready_i || at_limit);

  // Set wins over clear: a request landing on the granted bit in its
  // release cycle keeps that bit pending.
  always_comb begin
    pend_clr = '0;
    if (release_gnt) pend_clr = gnt_onehot_o;
    pend_n = (pend & ~pend_clr) | req_i;
  end

  // Priority chain over the registered pend only, so requests arriving in
  // the selection cycle wait for the next IDLE. Scanning downward lets the
  // lowest set index overwrite any higher one.
  always_comb begin
    sel_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = IDX_W'(i);
    end
    sel_onehot = N_REQ'(1) << sel_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pend         <= '0;
      wait_cnt     <= '0;
      gnt_valid_o  <= 1'b0;
      gnt_idx_o    <= '0;
      gnt_onehot_o <= '0;
      timeout_o    <= 1'b0;
      busy_o       <= 1'b0;
`ifdef PRIO_MULTI_HIT_EN
      multi_hit_o  <= 1'b0;
`endif
    end else begin
      pend      <= pend_n;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|pend) begin
            state        <= GRANT;
            wait_cnt     <= '0;
            gnt_valid_o  <= 1'b1;
            gnt_idx_o    <= sel_idx;
            gnt_onehot_o <= sel_onehot;
            busy_o       <= 1'b1;
`ifdef PRIO_MULTI_HIT_EN
            multi_hit_o  <= |(pend & (pend - N_REQ'(1)));
`endif
          end else begin
            busy_o <= |pend_n;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            gnt_valid_o  <= 1'b0;
            gnt_onehot_o <= '0;
            busy_o       <= |pend_n;
            // Accept takes precedence over a drop in the limit cycle.
            timeout_o    <= ~gnt_ready_i;
`ifdef PRIO_MULTI_HIT_EN
            multi_hit_o  <= 1'b0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            busy_o   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_req_granter.sv
// Directed bench for prio_req_granter (N_REQ=4, WAIT_MAX=15).
module tb_prio_req_granter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       gnt_ready_i;
  logic       gnt_valid_o;
  logic [1:0] gnt_idx_o;
  logic [3:0] gnt_onehot_o;
  logic       timeout_o;
  logic       busy_o;
`ifdef PRIO_MULTI_HIT_EN
  logic       multi_hit_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  prio_req_granter #(.N_REQ(4), .IDX_W(2), .WAIT_MAX(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .gnt_valid_o  (gnt_valid_o),
    .gnt_ready_i  (gnt_ready_i),
    .gnt_idx_o    (gnt_idx_o),
    .gnt_onehot_o (gnt_onehot_o),
    .timeout_o    (timeout_o),
`ifdef PRIO_MULTI_HIT_EN
    .multi_hit_o  (multi_hit_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] idx);
    chk({tag, "_valid"}, 32'(gnt_valid_o), 32'd1);
    chk({tag, "_idx"}, 32'(gnt_idx_o), 32'(idx));
    chk({tag, "_onehot"}, 32'(gnt_onehot_o), 32'(4'b0001 << idx));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(gnt_valid_o), 32'd0);
    chk({tag, "_onehot"}, 32'(gnt_onehot_o), 32'd0);
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req_i = r;
    tick();
    req_i = 4'b0000;
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    req_i = 4'b1111;
    gnt_ready_i = 1'b0;

    // reset with all requests high
    repeat (3) tick();
    chk("rst_valid", 32'(gnt_valid_o), 32'd0);
    chk("rst_idx", 32'(gnt_idx_o), 32'd0);
    chk("rst_onehot", 32'(gnt_onehot_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
`ifdef PRIO_MULTI_HIT_EN
    chk("rst_multi", 32'(multi_hit_o), 32'd0);
`endif

    // release: pend set at first edge, grant visible after the second
    rst = 1'b0;
    tick();
    req_i = 4'b0000;
    chk("rel_bubble", 32'(gnt_valid_o), 32'd0);
    chk("rel_busy", 32'(busy_o), 32'd1);
    tick();
    chk_grant("rel_g0", 2'd0);
`ifdef PRIO_MULTI_HIT_EN
    chk("rel_multi", 32'(multi_hit_o), 32'd1);
`endif
    gnt_ready_i = 1'b1;
    tick(); chk_bubble("rel_b0");
    tick(); chk_grant("rel_g1", 2'd1);
    tick(); chk_bubble("rel_b1");
    tick(); chk_grant("rel_g2", 2'd2);
    tick(); chk_bubble("rel_b2");
    tick(); chk_grant("rel_g3", 2'd3);
    tick(); chk_bubble("rel_b3");
    chk("rel_busy_end", 32'(busy_o), 32'd0);

    // priority: 1010 -> idx1 then idx3
    pulse_req(4'b1010);
    chk_bubble("pri_lat");
    tick(); chk_grant("pri_g1", 2'd1);
`ifdef PRIO_MULTI_HIT_EN
    chk("pri_multi1", 32'(multi_hit_o), 32'd1);
`endif
    tick(); chk_bubble("pri_b1");
    tick(); chk_grant("pri_g3", 2'd3);
`ifdef PRIO_MULTI_HIT_EN
    chk("pri_multi3", 32'(multi_hit_o), 32'd0);
`endif
    tick(); chk_bubble("pri_b3");
    chk("pri_busy", 32'(busy_o), 32'd0);

    // stall/hold: idx2 held 6 cycles, ready in the 6th
    gnt_ready_i = 1'b0;
    pulse_req(4'b0100);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_grant("hold", 2'd2);
      chk("hold_to", 32'(timeout_o), 32'd0);
      tick();
    end
    chk_grant("hold6", 2'd2);
    gnt_ready_i = 1'b1;
    tick();
    chk_bubble("hold_end");
    chk("hold_to_end", 32'(timeout_o), 32'd0);
    chk("hold_busy", 32'(busy_o), 32'd0);

    // no preemption: idx2 held while req0 arrives, then idx0 follows
    gnt_ready_i = 1'b0;
    pulse_req(4'b0100);
    tick();
    pulse_req(4'b0001);
    chk_grant("npre_a", 2'd2);
    tick();
    chk_grant("npre_b", 2'd2);
    gnt_ready_i = 1'b1;
    tick(); chk_bubble("npre_bub");
    tick(); chk_grant("npre_g0", 2'd0);
    tick(); chk_bubble("npre_end");

    // timeout: valid for exactly 15 cycles, then timeout pulse
    gnt_ready_i = 1'b0;
    pulse_req(4'b0001);
    tick();
    cnt = 0;
    while (gnt_valid_o === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_cycles", 32'(cnt), 32'd15);
    chk("to_pulse", 32'(timeout_o), 32'd1);
    chk("to_valid", 32'(gnt_valid_o), 32'd0);
    chk("to_busy", 32'(busy_o), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout_o), 32'd0);

    // ready in the limit cycle: accept wins
    pulse_req(4'b0001);
    tick();
    repeat (14) tick();
    chk_grant("lim_g", 2'd0);
    gnt_ready_i = 1'b1;
    tick();
    chk("lim_to", 32'(timeout_o), 32'd0);
    chk_bubble("lim_bub");
    chk("lim_busy", 32'(busy_o), 32'd0);

    // set over clear: req0 in the accept cycle of the idx0 grant
    pulse_req(4'b0001);
    tick();
    chk_grant("soc_g1", 2'd0);
    pulse_req(4'b0001);
    chk_bubble("soc_bub");
    chk("soc_busy", 32'(busy_o), 32'd1);
    tick(); chk_grant("soc_g2", 2'd0);
    tick(); chk_bubble("soc_end");
    chk("soc_busy_end", 32'(busy_o), 32'd0);

    // mid-grant asynchronous reset
    gnt_ready_i = 1'b0;
    pulse_req(4'b0010);
    tick();
    chk_grant("mrst_g", 2'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(gnt_valid_o), 32'd0);
    chk("mrst_onehot", 32'(gnt_onehot_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mrst_post_to", 32'(timeout_o), 32'd0);
      chk("mrst_post_valid", 32'(gnt_valid_o), 32'd0);
      chk("mrst_post_busy", 32'(busy_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
